// File: rtl/counter_updown_n_if.sv
// Bus bundle for counter_updown_n: count/load controls in, count and terminal count out.
//   master : drives i_cep, i_cet, i_ud, i_pe_n, i_d; observes o_q, o_tc_c
//   slave  : the counter itself
//   i_cep  count enable (parallel)
//   i_cet  count enable (trickle), also gates o_tc_c
//   i_ud   direction, 1 = up, 0 = down
//   i_pe_n active-low synchronous parallel load
//   i_d    parallel load data
//   o_q    registered count value
//   o_tc_c terminal count, combinational from count, i_cet and i_ud
interface counter_updown_n_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             i_cep;
  logic             i_cet;
  logic             i_ud;
  logic             i_pe_n;
  logic [WIDTH-1:0] i_d;
  logic [WIDTH-1:0] o_q;
  logic             o_tc_c;

  modport master (
    output i_cep, i_cet, i_ud, i_pe_n, i_d,
    input  o_q, o_tc_c
  );

  modport slave (
    input  i_cep, i_cet, i_ud, i_pe_n, i_d,
    output o_q, o_tc_c
  );
endinterface

// File: rtl/counter_updown_n.sv
// WIDTH-bit synchronous up/down counter with parallel load, programmable
// modulus and cascadable enables (CEP/CET -> TC).
// Ports:
//   i_cp   clock, all synchronous actions on the rising edge
//   i_mr_n asynchronous active-low master reset, clears the count
//   bus    counter_updown_n_if.slave (enables, direction, load, data, Q, TC)
// Optional feature macro: COUNTER_UPDOWN_N_SATURATE_EN
//   defined   : a step at the terminal value holds instead of wrapping
//   undefined : wrap (up past MODULUS-1 -> 0, down past 0 -> MODULUS-1)
// PD_* parameters document the board-level timing of the original part;
// they carry no delay into this synchronous implementation.
module counter_updown_n #(
  parameter string           NAME      = "counter_updown_n",
  parameter int unsigned     WIDTH     = 4,
  parameter longint unsigned MODULUS   = 16,
  parameter int              PD_Q      = 20,
  parameter int              PD_TC     = 25,
  parameter int              PD_CET_TC = 14
) (
  input  logic               i_cp,
  input  logic               i_mr_n,
  counter_updown_n_if.slave  bus
);

  // Terminal up value; MODULUS may equal 2^WIDTH so compute in 64 bits first.
  localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 64'd1);

`ifdef COUNTER_UPDOWN_N_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  // Elaboration-time sanity check of the parameter set.
  if (WIDTH == 0 || WIDTH > 32 || MODULUS < 64'd2 ||
      MODULUS > (64'd1 << WIDTH) ||
      PD_Q < 0 || PD_TC < 0 || PD_CET_TC < 0) begin : g_bad_param
    $error("%s: illegal parameter set", NAME);
  end

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic             w_at_top;
  logic             w_at_zero;

  // Out-of-range values (> TERM) count as "at top" for stepping, not for TC.
  assign w_at_top  = (r_q >= TERM);
  assign w_at_zero = (r_q == '0);

  // Next-count selection: load beats step beats hold.
  always_comb begin
    w_q_next = r_q;
    if (!bus.i_pe_n) begin
      w_q_next = bus.i_d;
    end else if (bus.i_cep && bus.i_cet) begin
      if (bus.i_ud) begin
        if (w_at_top) w_q_next = SATURATE ? r_q : '0;
        else          w_q_next = r_q + WIDTH'(1);
      end else begin
        if (w_at_zero) w_q_next = SATURATE ? r_q : TERM;
        else           w_q_next = r_q - WIDTH'(1);
      end
    end
  end

  // Count register; reset is asynchronous and overrides any load or step.
  always_ff @(posedge i_cp or negedge i_mr_n) begin
    if (!i_mr_n) r_q <= '0;
    else         r_q <= w_q_next;
  end

  assign bus.o_q = r_q;

  // TC uses exact equality so out-of-range values never flag in up mode.
  assign bus.o_tc_c = bus.i_cet & (bus.i_ud ? (r_q == TERM) : w_at_zero);

endmodule

// File: tb/tb_counter_updown_n.sv
// Self-checking bench for counter_updown_n (WIDTH=4, MODULUS=10), with a
// second cascaded stage fed from the first stage's TC.
module tb_counter_updown_n;

  localparam int unsigned     W = 4;
  localparam longint unsigned M = 10;
`ifdef COUNTER_UPDOWN_N_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    bit         edge_en;
    logic       pe_n;
    logic       cep;
    logic       cet;
    logic       ud;
    logic [3:0] d;
    logic [3:0] q;
    logic       tc;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic       tc;
  } exp_t;

  logic clk = 1'b0;
  logic mr_n;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  counter_updown_n_if #(.WIDTH(W)) bus0 ();
  counter_updown_n_if #(.WIDTH(W)) bus1 ();

  assign bus1.i_cep  = bus0.i_cep;
  assign bus1.i_cet  = bus0.o_tc_c;
  assign bus1.i_ud   = 1'b1;
  assign bus1.i_pe_n = 1'b1;
  assign bus1.i_d    = '0;

  counter_updown_n #(.NAME("u_stage0"), .WIDTH(W), .MODULUS(M)) u_stage0 (
    .i_cp  (clk),
    .i_mr_n(mr_n),
    .bus   (bus0.slave)
  );

  counter_updown_n #(.NAME("u_stage1"), .WIDTH(W), .MODULUS(M)) u_stage1 (
    .i_cp  (clk),
    .i_mr_n(mr_n),
    .bus   (bus1.slave)
  );

  function automatic void add(input bit e, input logic pe_n, input logic cep,
                              input logic cet, input logic ud, input logic [3:0] d,
                              input logic [3:0] q, input logic tc);
    vecs.push_back('{edge_en: e, pe_n: pe_n, cep: cep, cet: cet, ud: ud,
                     d: d, q: q, tc: tc});
  endfunction

  function automatic void expect_out(input logic [7:0] q, input logic tc);
    sb.push_back('{q: q, tc: tc});
  endfunction

  task automatic check(input string name, input logic [7:0] aq, input logic atc);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s: no expected value queued (got q=%0h tc=%b)", name, aq, atc);
    end else begin
      e = sb.pop_front();
      if (aq !== e.q || atc !== e.tc) begin
        n_bad++;
        $display("FAIL %s: got q=%0h tc=%b, want q=%0h tc=%b", name, aq, atc, e.q, e.tc);
      end
    end
  endtask

  task automatic check0(input string name);
    check(name, {4'h0, bus0.o_q}, bus0.o_tc_c);
  endtask

  task automatic check_cascade(input string name);
    check(name, {bus1.o_q, bus0.o_q}, bus1.o_tc_c);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit in_low;

    // Up count through terminal
    for (int i = 1; i <= 9; i++) add(1, 1, 1, 1, 1, 4'h0, 4'(i), (i == 9));
    add(1, 1, 1, 1, 1, 4'h0, SAT ? 4'd9 : 4'd0, SAT);
    // Down from zero
    add(1, 0, 1, 1, 0, 4'h0, 4'd0, 1'b1);
    add(0, 1, 1, 1, 0, 4'h0, 4'd0, 1'b1);
    add(1, 1, 1, 1, 0, 4'h0, SAT ? 4'd0 : 4'd9, SAT);
    add(1, 0, 1, 1, 0, 4'h9, 4'd9, 1'b0);
    for (int i = 8; i >= 6; i--) add(1, 1, 1, 1, 0, 4'h0, 4'(i), 1'b0);
    // Out-of-range loads
    add(1, 0, 1, 1, 1, 4'hC, 4'd12, 1'b0);
    add(1, 1, 1, 1, 1, 4'h0, SAT ? 4'd12 : 4'd0, 1'b0);
    add(1, 0, 1, 1, 0, 4'hC, 4'd12, 1'b0);
    add(1, 1, 1, 1, 0, 4'h0, 4'd11, 1'b0);
    add(1, 0, 1, 1, 0, 4'hF, 4'd15, 1'b0);
    add(1, 1, 1, 1, 0, 4'h0, 4'd14, 1'b0);
    // TC follows UD without an edge
    add(1, 0, 1, 1, 1, 4'h0, 4'd0, 1'b0);
    add(0, 1, 0, 1, 0, 4'h0, 4'd0, 1'b1);
    // Enable gating at the terminal value
    add(1, 0, 1, 1, 1, 4'h9, 4'd9, 1'b1);
    add(1, 1, 1, 0, 1, 4'h0, 4'd9, 1'b0);
    add(1, 1, 1, 0, 1, 4'h0, 4'd9, 1'b0);
    add(1, 1, 0, 1, 1, 4'h0, 4'd9, 1'b1);
    add(1, 1, 0, 1, 1, 4'h0, 4'd9, 1'b1);
    add(1, 0, 0, 0, 1, 4'h3, 4'd3, 1'b0);
    // Terminal wrap / saturate in both directions
    add(1, 0, 1, 1, 1, 4'h9, 4'd9, 1'b1);
    add(1, 1, 1, 1, 1, 4'h0, SAT ? 4'd9 : 4'd0, SAT);
    add(1, 1, 1, 1, 1, 4'h0, SAT ? 4'd9 : 4'd1, SAT);
    add(1, 0, 1, 1, 0, 4'h0, 4'd0, 1'b1);
    add(1, 1, 1, 1, 0, 4'h0, SAT ? 4'd0 : 4'd9, SAT);

    // Asynchronous reset from power-up
    mr_n = 1'b1;
    bus0.i_pe_n = 1'b1; bus0.i_cep = 1'b1; bus0.i_cet = 1'b1;
    bus0.i_ud = 1'b1;   bus0.i_d = 4'h0;
    #2 mr_n = 1'b0;
    expect_out(8'h00, 1'b0);
    #1 check0("por_reset");
    @(negedge clk) mr_n = 1'b1;

    // Cascade: 99 edges -> 9:9, then 0:0
    repeat (50) @(posedge clk);
    #1;
    expect_out(SAT ? 8'h99 : 8'h50, SAT);
    check_cascade("cascade_50");
    repeat (49) @(posedge clk);
    #1;
    expect_out(8'h99, 1'b1);
    check_cascade("cascade_99");
    @(posedge clk);
    #1;
    expect_out(SAT ? 8'h99 : 8'h00, SAT);
    check_cascade("cascade_100");

    // Reset again mid-cycle, hold while released
    @(negedge clk);
    bus0.i_cep = 1'b0;
    #2 mr_n = 1'b0;
    expect_out(8'h00, 1'b0);
    #1 check_cascade("reset_both");
    @(negedge clk) mr_n = 1'b1;
    in_low = 1'b1;

    foreach (vecs[i]) begin
      if (!in_low) @(negedge clk);
      bus0.i_pe_n = vecs[i].pe_n;
      bus0.i_cep  = vecs[i].cep;
      bus0.i_cet  = vecs[i].cet;
      bus0.i_ud   = vecs[i].ud;
      bus0.i_d    = vecs[i].d;
      expect_out({4'h0, vecs[i].q}, vecs[i].tc);
      if (vecs[i].edge_en) @(posedge clk);
      #1;
      check0($sformatf("vec%0d", i));
      in_low = !vecs[i].edge_en;
    end

    // Reset asserted mid-cycle at Q=7, then a load edge while still in reset
    @(negedge clk);
    bus0.i_pe_n = 1'b0; bus0.i_d = 4'h7; bus0.i_ud = 1'b0;
    bus0.i_cep = 1'b1;  bus0.i_cet = 1'b1;
    expect_out(8'h07, 1'b0);
    @(posedge clk);
    #1 check0("load7");
    #2 mr_n = 1'b0;
    expect_out(8'h00, 1'b1);
    #1 check0("mr_mid_cycle");
    @(negedge clk);
    bus0.i_d = 4'h5;
    expect_out(8'h00, 1'b1);
    @(posedge clk);
    #1 check0("load_during_mr");
    @(negedge clk) mr_n = 1'b1;
    expect_out(8'h00, 1'b1);
    #1 check0("mr_release");
    expect_out(8'h05, 1'b0);
    @(posedge clk);
    #1 check0("first_edge_after_mr");

    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
